// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle for sobel_window_gen.
// in_sof exists only when SOBEL_WIN_SOF_EN is defined.
interface sobel_window_gen_if #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic          in_valid;
  logic [DW-1:0] in_data;
`ifdef SOBEL_WIN_SOF_EN
  logic          in_sof;
`endif
  logic [DW-1:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic          win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          win_last;
  logic          frame_done;

  modport master (
    output in_valid, in_data,
`ifdef SOBEL_WIN_SOF_EN
    output in_sof,
`endif
    input  p0, p1, p2, p3, p5, p6, p7, p8,
    input  win_valid, win_x, win_y, win_last, frame_done
  );

  modport slave (
    input  in_valid, in_data,
`ifdef SOBEL_WIN_SOF_EN
    input  in_sof,
`endif
    output p0, p1, p2, p3, p5, p6, p7, p8,
    output win_valid, win_x, win_y, win_last, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3-window generator feeding the Sobel operator; two line buffers + 3x3 register window.
// Optional SOBEL_WIN_SOF_EN: an accept with in_sof restarts the frame at pixel (0,0).
module sobel_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input logic              clk,
  input logic              rst,
  sobel_window_gen_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

  logic [XW-1:0] x_q, x_d, cx;
  logic [YW-1:0] y_q, y_d, cy;
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];
  logic [DW-1:0] lb0_rd, lb1_rd;

  // Index 0 = col0 (oldest), index 2 = col2 (newest)
  logic [2:0][DW-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;

  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic          frame_done_q, frame_done_d;
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;

  logic accept, row_end, at_last, emit;

  // Effective coordinate of the pixel being accepted (SOF overrides the counters)
  always_comb begin
    cx = x_q;
    cy = y_q;
`ifdef SOBEL_WIN_SOF_EN
    if (bus.in_sof) begin
      cx = '0;
      cy = '0;
    end
`endif
  end

  assign accept  = bus.in_valid;
  assign lb0_rd  = lb0_q[cx];
  assign lb1_rd  = lb1_q[cx];
  assign row_end = (cx == XMAX);
  assign at_last = row_end && (cy == YMAX);
  assign emit    = accept && (cx >= XW'(2)) && (cy >= YW'(2));

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    top_d        = top_q;
    mid_d        = mid_q;
    bot_d        = bot_q;
    win_valid_d  = emit;
    win_last_d   = emit && at_last;
    frame_done_d = accept && at_last;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    if (accept) begin
      if (row_end) begin
        x_d = '0;
        y_d = (cy == YMAX) ? '0 : cy + YW'(1);
      end else begin
        x_d = cx + XW'(1);
        y_d = cy;
      end
      top_d = {lb1_rd, top_q[2], top_q[1]};
      mid_d = {lb0_rd, mid_q[2], mid_q[1]};
      bot_d = {bus.in_data, bot_q[2], bot_q[1]};
    end
    if (emit) begin
      win_x_d = cx - XW'(1);
      win_y_d = cy - YW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
    end
  end

  // Line buffers keep contents across reset and frames; rows 0/1 never emit, so stale data is harmless
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[cx] <= lb0_rd;
      lb0_q[cx] <= bus.in_data;
    end
  end

  assign bus.p0         = top_q[0];
  assign bus.p1         = top_q[1];
  assign bus.p2         = top_q[2];
  assign bus.p3         = mid_q[0];
  assign bus.p5         = mid_q[2];
  assign bus.p6         = bot_q[0];
  assign bus.p7         = bot_q[1];
  assign bus.p8         = bot_q[2];
  assign bus.win_valid  = win_valid_q;
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
  assign bus.win_last   = win_last_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: frame-image reference model with scoreboard, random gaps and data.
module tb_sobel_window_gen;
  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.IMG_W(W), .IMG_H(H), .DW(8)) bus ();
  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] p [8];
    int         x;
    int         y;
    bit         last;
  } win_t;

  win_t       exp_q[$];
  logic [7:0] img [H][W];
  int         mx, my;
  int         total, bad;
  int         win_cnt, fd_cnt, fd0;
  int         hold_x, hold_y;
  logic [7:0] first_p [8];
  logic [7:0] last_p [8];
  logic       last_fd, last_wl;
  logic [7:0] ref_p [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_arr(input string tag, input logic [7:0] got [8], input logic [7:0] e [8]);
    for (int i = 0; i < 8; i++) begin
      total++;
      assert (got[i] === e[i]) else begin
        bad++;
        $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, got[i], e[i]);
      end
    end
  endtask

  task automatic check_cycle();
    logic [7:0] dp [8];
    win_t w;
    dp = '{bus.p0, bus.p1, bus.p2, bus.p3, bus.p5, bus.p6, bus.p7, bus.p8};
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.win_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_window", 32'(1), 32'(0));
      end else begin
        w = exp_q.pop_front();
        chk_arr("win_p", dp, w.p);
        chk("win_x", 32'(bus.win_x), 32'(w.x));
        chk("win_y", 32'(bus.win_y), 32'(w.y));
        chk("win_last", 32'(bus.win_last), 32'(w.last));
        chk("frame_done_w", 32'(bus.frame_done), 32'(w.last));
        hold_x = w.x;
        hold_y = w.y;
      end
      if (win_cnt == 0) first_p = dp;
      last_p  = dp;
      last_fd = bus.frame_done;
      last_wl = bus.win_last;
      win_cnt++;
    end else begin
      chk("win_valid_idle", 32'(bus.win_valid), 32'(0));
      chk("missing_window", 32'(exp_q.size()), 32'(0));
      chk("hold_win_x", 32'(bus.win_x), 32'(hold_x));
      chk("hold_win_y", 32'(bus.win_y), 32'(hold_y));
      chk("frame_done_idle", 32'(bus.frame_done), 32'(0));
      exp_q.delete();
    end
  endtask

  // Reference: the frame as an image; a window is the 3x3 block ending at the accepted pixel
  task automatic model_accept(input logic [7:0] d, input bit sof);
    win_t w;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = d;
    if (mx >= 2 && my >= 2) begin
      w.p = '{img[my-2][mx-2], img[my-2][mx-1], img[my-2][mx],
              img[my-1][mx-2], img[my-1][mx],
              img[my][mx-2],   img[my][mx-1],   img[my][mx]};
      w.x = mx - 1;
      w.y = my - 1;
      w.last = (mx == W - 1) && (my == H - 1);
      exp_q.push_back(w);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit sof);
    bus.in_valid = v;
    bus.in_data  = v ? d : 8'($urandom);
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof   = v ? sof : 1'($urandom);
`endif
    if (v) model_accept(d, sof);
    @(posedge clk);
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  function automatic logic [7:0] pix(input int kind, input int k);
    case (kind)
      0:       return 8'(k);
      1:       return 8'(255 - k);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic send(input int kind, input int gap, input bit first_sof, input int npix);
    for (int k = 0; k < npix; k++) begin
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap; g++) step(1'b0, 8'd0, 1'b0);
      step(1'b1, pix(kind, k), first_sof && (k == 0));
    end
    step(1'b0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    logic [7:0] dp [8];
    logic [7:0] zero [8];
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof   = 1'b0;
`endif
    exp_q.delete();
    hold_x = 0;
    hold_y = 0;
    mx = 0;
    my = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    win_cnt = 0;
    dp   = '{bus.p0, bus.p1, bus.p2, bus.p3, bus.p5, bus.p6, bus.p7, bus.p8};
    zero = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    chk_arr("reset_p", dp, zero);
    chk("reset_win_valid", 32'(bus.win_valid), 32'(0));
    chk("reset_win_last", 32'(bus.win_last), 32'(0));
    chk("reset_frame_done", 32'(bus.frame_done), 32'(0));
    chk("reset_win_x", 32'(bus.win_x), 32'(0));
    chk("reset_win_y", 32'(bus.win_y), 32'(0));
  endtask

  task automatic check_ramp_frame(input string tag, input bit inv);
    if (inv) ref_p = '{8'd255, 8'd254, 8'd253, 8'd247, 8'd245, 8'd239, 8'd238, 8'd237};
    else     ref_p = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd10, 8'd16, 8'd17, 8'd18};
    chk_arr({tag, "_first"}, first_p, ref_p);
    if (inv) ref_p = '{8'd210, 8'd209, 8'd208, 8'd202, 8'd200, 8'd194, 8'd193, 8'd192};
    else     ref_p = '{8'd45, 8'd46, 8'd47, 8'd53, 8'd55, 8'd61, 8'd62, 8'd63};
    chk_arr({tag, "_last"}, last_p, ref_p);
    chk({tag, "_count"}, 32'(win_cnt), 32'(36));
    chk({tag, "_last_fd"}, 32'(last_fd), 32'(1));
    chk({tag, "_last_wl"}, 32'(last_wl), 32'(1));
    chk({tag, "_last_x"}, 32'(hold_x), 32'(6));
    chk({tag, "_last_y"}, 32'(hold_y), 32'(6));
    chk({tag, "_fd_cnt"}, 32'(fd_cnt), 32'(fd0 + 1));
    win_cnt = 0;
    fd0 = fd_cnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; win_cnt = 0; fd_cnt = 0; fd0 = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof   = 1'b0;
`endif
    @(negedge clk);
    do_reset();
    fd0 = fd_cnt;

    // Continuous ramp
    send(0, 0, 1'b0, W * H);
    check_ramp_frame("ramp", 1'b0);

    // Ramp with ~50% gaps
    send(0, 50, 1'b0, W * H);
    check_ramp_frame("ramp_gaps", 1'b0);

    // Inverted ramp right after
    send(1, 0, 1'b0, W * H);
    check_ramp_frame("inv_ramp", 1'b1);

    // Random pixel data with gaps
    send(2, 30, 1'b0, W * H);
    chk("random_count", 32'(win_cnt), 32'(36));
    chk("random_fd_cnt", 32'(fd_cnt), 32'(fd0 + 1));
    win_cnt = 0;
    fd0 = fd_cnt;

    // Reset after pixel 30, then full ramp
    send(0, 20, 1'b0, 31);
    do_reset();
    fd0 = fd_cnt;
    send(0, 0, 1'b0, W * H);
    check_ramp_frame("ramp_after_rst", 1'b0);

`ifdef SOBEL_WIN_SOF_EN
    // Abort at pixel 20 with an SOF-flagged ramp restart
    send(0, 30, 1'b0, 20);
    chk("sof_partial_fd", 32'(fd_cnt), 32'(fd0));
    win_cnt = 0;
    send(0, 30, 1'b1, W * H);
    check_ramp_frame("sof_restart", 1'b0);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window stage directly upstream of the Sobel `top_level` operator. Accepts one 8-bit pixel per valid cycle in row-major order and keeps two line buffers plus a 3x3 register window. For every interior centre pixel it presents the eight neighbours `p0..p8` (no `p4`) with a valid strobe and centre coordinates. Border centres produce no window; the downstream writer fills them with 0.

## Interface
Parameters:
- `IMG_W`, 8: pixels per row, ≥3.
- `IMG_H`, 8: rows per frame, ≥3.
- `DW`, 8: pixel width.

Ports (`XW = $clog2(IMG_W)`, `YW = $clog2(IMG_H)`):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` is valid this cycle; pixel is accepted (always ready).
- `in_data` in DW: pixel value.
- `in_sof` in 1: start of frame, sampled only with `in_valid` (present only with `SOBEL_WIN_SOF_EN`).
- `p0,p1,p2,p3,p5,p6,p7,p8` out DW each: neighbours, row-major top-left to bottom-right.
- `win_valid` out 1: window outputs are valid, one-cycle pulse per window.
- `win_x` out XW: centre column, range 1..IMG_W-2.
- `win_y` out YW: centre row, range 1..IMG_H-2.
- `win_last` out 1: last window of frame, qualified by `win_valid`.
- `frame_done` out 1: one-cycle pulse after pixel (IMG_W-1, IMG_H-1) is accepted.

## Operation
- Position counters `x`, `y` give the coordinate of the pixel being accepted.
  - On accept, `x` increments.
  - At `x = IMG_W-1`, `x` goes to 0 and `y` increments.
  - At (IMG_W-1, IMG_H-1), both go to 0.
- Line buffers: `lb0` holds the previous row and `lb1` the row before it. Each is IMG_W deep, indexed by `x`.
  - On accept, read `lb0[x]` and `lb1[x]` first.
  - Then write `lb1[x] <= lb0[x]` and `lb0[x] <= in_data`.
- Window: three columns of three registers. On accept:
  - col0 <= col1, col1 <= col2.
  - col2 <= {`lb1[x]`, `lb0[x]`, `in_data`} for {top, mid, bottom}.
- Output mapping:
  - `p0/p1/p2` = top row of col0/col1/col2.
  - `p3/p5` = mid row of col0/col2.
  - `p6/p7/p8` = bottom row of col0/col1/col2.
- Window emission: an accept with `x ≥ 2` and `y ≥ 2` yields a window next cycle.
  - Centre is (`x-1`, `y-1`).
  - Accepts with `x < 2` only shift the window; no emission.
  - Windows never straddle rows.
- Count: exactly (IMG_W-2)·(IMG_H-2) windows per frame.
- Idle cycles (`in_valid = 0`): no state changes, no emission. `p*`, `win_x`, `win_y` hold.
- Line-buffer contents are not cleared between frames. Stale data is never emitted, because row 0 and row 1 produce no windows.

## Timing
- Latency: one cycle from the accepting edge to `win_valid`, with `p*`/`win_x`/`win_y`/`win_last` registered on the same edge.
- Back-to-back accepts give back-to-back windows within a row. Each row has a 2-cycle emission gap at x = 0, 1.
- `win_last` and `frame_done` assert in the same cycle (from the accept of pixel (IMG_W-1, IMG_H-1)).
- Reset values:
  - `win_valid`, `win_last`, `frame_done` = 0.
  - `p*` = 0, `win_x` = 0, `win_y` = 0.
  - `x` = `y` = 0; window registers = 0.
  - Line buffers are not reset.
- Reset mid-frame: next accepted pixel is (0,0). No window is emitted until row 2, column 2 of the new frame.

## Configuration
- `SOBEL_WIN_SOF_EN` defined:
  - The `in_sof` port exists.
  - An accept with `in_sof = 1` is treated as pixel (0,0), and counters continue from there. Any partial frame is abandoned without `frame_done`.
  - `in_sof` with `in_valid = 0` is ignored.
- Not defined:
  - The port is absent.
  - Frames are delimited only by pixel count after reset.

## Test plan
- Ramp frame, 8x8, pixel(x,y) = 8y+x, continuous `in_valid`:
  - First window one cycle after pixel 18: `win_x = 1`, `win_y = 1`, `p0..p8` = 0,1,2,8,10,16,17,18.
  - 36 windows total.
- Same frame, last window:
  - Centre (6,6), `p0..p8` = 45,46,47,53,55,61,62,63.
  - `win_last = 1` and `frame_done = 1` in the same cycle.
- Random `in_valid` gaps (~50%) on the ramp: window sequence and values identical to the continuous run; outputs hold during gaps.
- Two consecutive frames, second = 255 - ramp: second frame's first window `p0..p8` = 255,254,253,247,245,239,238,237.
- `rst` pulsed after pixel 30, then the full ramp is restarted: no window before pixel 18 of the new frame; first window = 0,1,2,8,10,16,17,18.
- With `SOBEL_WIN_SOF_EN`, `in_sof` asserted on pixel 20 with a ramp restart:
  - No `frame_done` for the aborted frame.
  - Subsequent 36 windows match the ramp test.
